// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Arbitrates two requesters onto one shared, tri-stated main-memory bus.
// Each granted transaction moves one cache line of BURST_LEN beats. Reads
// issue a single READ command cycle and then collect RESPONSE beats. Writes
// stream BURST_LEN beats and then wait for a single RESPONSE. A DONE cycle
// always separates two transactions, so the shared bus gets one idle
// turnaround cycle between owners.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_cmd_i / req_addr_i            requester i operation (NOP/READ/WRITE)
//                                     and line address
//   req_wdata_i                       requester i write beat
//   gnt_i                             requester i owns the bus
//   wready_i                          req_wdata_i is consumed this cycle
//   rvalid_i / rdata_i                read beat for requester i
//   done_i / err_i                    end-of-transaction pulse; err_i marks
//                                     a timeout
//   mem_address                       line address to memory (held)
//   mem_data, mem_command             shared tri-state buses; memory drives
//                                     RESPONSE on mem_command
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int BUS_SIZE  = 16,
    parameter int ADDR_SIZE = 15,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req_cmd_0,
    input  logic [ADDR_SIZE-1:0] req_addr_0,
    input  logic [BUS_SIZE-1:0]  req_wdata_0,
    output logic                 gnt_0,
    output logic                 wready_0,
    output logic                 rvalid_0,
    output logic [BUS_SIZE-1:0]  rdata_0,
    output logic                 done_0,
    output logic                 err_0,
    input  logic [1:0]           req_cmd_1,
    input  logic [ADDR_SIZE-1:0] req_addr_1,
    input  logic [BUS_SIZE-1:0]  req_wdata_1,
    output logic                 gnt_1,
    output logic                 wready_1,
    output logic                 rvalid_1,
    output logic [BUS_SIZE-1:0]  rdata_1,
    output logic                 done_1,
    output logic                 err_1,
    output logic [ADDR_SIZE-1:0] mem_address,
    inout  wire  [BUS_SIZE-1:0]  mem_data,
    inout  wire  [1:0]           mem_command
);

    localparam logic [1:0] C2_NOP      = 2'd0;
    localparam logic [1:0] C2_RESPONSE = 2'd1;
    localparam logic [1:0] C2_READ     = 2'd2;
    localparam logic [1:0] C2_WRITE    = 2'd3;

    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT, DONE
    } state_t;

    // Per-requester inputs gathered into arrays so the datapath can be
    // indexed by the current owner.
    logic [1:0]           req_cmd   [2];
    logic [ADDR_SIZE-1:0] req_addr  [2];
    logic [BUS_SIZE-1:0]  req_wdata [2];
    logic [1:0]           pending;
    logic [1:0]           gnt;
    logic [1:0]           wready;
    logic [1:0]           rvalid;
    logic [1:0]           done;

    assign req_cmd[0]   = req_cmd_0;
    assign req_cmd[1]   = req_cmd_1;
    assign req_addr[0]  = req_addr_0;
    assign req_addr[1]  = req_addr_1;
    assign req_wdata[0] = req_wdata_0;
    assign req_wdata[1] = req_wdata_1;

    state_t                state_reg,       state_next;
    logic                  ptr_reg,         ptr_next;
    logic                  owner_reg,       owner_next;
    logic [ADDR_SIZE-1:0]  mem_address_reg, mem_address_next;
    logic [BEAT_W-1:0]     beat_cnt_reg,    beat_cnt_next;
    logic [TMR_W-1:0]      timer_reg,       timer_next;
    logic                  rvalid_reg,      rvalid_next;
    logic [BUS_SIZE-1:0]   rdata_reg,       rdata_next;
    logic                  err_reg,         err_next;

    logic                  grant_sel;
    logic                  cmd_oe;
    logic [1:0]            cmd_out;
    logic                  data_oe;
    logic [BUS_SIZE-1:0]   data_out;
    logic                  wready_any;
    logic                  resp;

    // The command bus only carries RESPONSE while nobody here drives it, so
    // comparing the resolved bus value is enough to detect a memory beat.
    assign resp = (mem_command == C2_RESPONSE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= 1'b0;
            owner_reg       <= 1'b0;
            mem_address_reg <= '0;
            beat_cnt_reg    <= '0;
            timer_reg       <= '0;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= '0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            owner_reg       <= owner_next;
            mem_address_reg <= mem_address_next;
            beat_cnt_reg    <= beat_cnt_next;
            timer_reg       <= timer_next;
            rvalid_reg      <= rvalid_next;
            rdata_reg       <= rdata_next;
            err_reg         <= err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        owner_next       = owner_reg;
        mem_address_next = mem_address_reg;
        beat_cnt_next    = beat_cnt_reg;
        timer_next       = timer_reg;
        rvalid_next      = 1'b0;
        rdata_next       = rdata_reg;
        err_next         = err_reg;
        grant_sel        = 1'b0;
        cmd_oe           = 1'b0;
        cmd_out          = C2_NOP;
        data_oe          = 1'b0;
        data_out         = req_wdata[owner_reg];
        wready_any       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pending != 2'b00) begin
                    // Contention goes to the pointer; a lone requester wins
                    // regardless of where the pointer sits.
                    grant_sel        = (pending == 2'b11) ? ptr_reg : pending[1];
                    owner_next       = grant_sel;
                    mem_address_next = req_addr[grant_sel];
                    beat_cnt_next    = '0;
                    timer_next       = '0;
                    err_next         = 1'b0;
                    state_next       = (req_cmd[grant_sel] == C2_WRITE) ? WR_BURST : RD_CMD;
                end
            end
            RD_CMD: begin
                cmd_oe        = 1'b1;
                cmd_out       = C2_READ;
                timer_next    = '0;
                beat_cnt_next = '0;
                state_next    = RD_WAIT;
            end
            RD_WAIT, RD_BURST: begin
                if (resp) begin
                    rdata_next    = mem_data;
                    rvalid_next   = 1'b1;
                    timer_next    = '0;
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                    state_next    = (beat_cnt_reg == BEAT_W'(BURST_LEN - 1)) ? DONE : RD_BURST;
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            WR_BURST: begin
                cmd_oe     = 1'b1;
                cmd_out    = C2_WRITE;
                data_oe    = 1'b1;
                wready_any = 1'b1;
                if (beat_cnt_reg == BEAT_W'(BURST_LEN - 1)) begin
                    beat_cnt_next = '0;
                    timer_next    = '0;
                    state_next    = WR_WAIT;
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end
            WR_WAIT: begin
                if (resp) begin
                    state_next = DONE;
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            DONE: begin
                // Next contention favours whoever was not just served.
                ptr_next   = ~owner_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign pending[gi] = (req_cmd[gi] != C2_NOP);
            assign gnt[gi]     = (state_reg != IDLE) && (owner_reg == 1'(gi));
            assign wready[gi]  = wready_any && (owner_reg == 1'(gi));
            assign rvalid[gi]  = rvalid_reg && (owner_reg == 1'(gi));
            assign done[gi]    = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign gnt_0    = gnt[0];
    assign gnt_1    = gnt[1];
    assign wready_0 = wready[0];
    assign wready_1 = wready[1];
    assign rvalid_0 = rvalid[0];
    assign rvalid_1 = rvalid[1];
    assign rdata_0  = rdata_reg;
    assign rdata_1  = rdata_reg;
    assign done_0   = done[0];
    assign done_1   = done[1];
    assign err_0    = done[0] && err_reg;
    assign err_1    = done[1] && err_reg;

    assign mem_address = mem_address_reg;
    assign mem_command = cmd_oe  ? cmd_out  : 2'bzz;
    assign mem_data    = data_oe ? data_out : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int BUS_SIZE  = 16;
    localparam int ADDR_SIZE = 15;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT   = 255;

    localparam logic [1:0] C2_NOP      = 2'd0;
    localparam logic [1:0] C2_RESPONSE = 2'd1;
    localparam logic [1:0] C2_READ     = 2'd2;
    localparam logic [1:0] C2_WRITE    = 2'd3;

    logic clk = 1'b0;
    logic reset_n;
    logic [1:0]           req_cmd_0, req_cmd_1;
    logic [ADDR_SIZE-1:0] req_addr_0, req_addr_1;
    logic [BUS_SIZE-1:0]  req_wdata_0, req_wdata_1;
    logic gnt_0, wready_0, rvalid_0, done_0, err_0;
    logic gnt_1, wready_1, rvalid_1, done_1, err_1;
    logic [BUS_SIZE-1:0]  rdata_0, rdata_1;
    logic [ADDR_SIZE-1:0] mem_address;
    wire  [BUS_SIZE-1:0]  mem_data;
    wire  [1:0]           mem_command;

    // Memory model bus drivers
    logic                mem_cmd_drv;
    logic                mem_data_drv;
    logic [BUS_SIZE-1:0] mem_data_val;
    assign mem_command = mem_cmd_drv  ? C2_RESPONSE : 2'bzz;
    assign mem_data    = mem_data_drv ? mem_data_val : {BUS_SIZE{1'bz}};

    // Memory model configuration
    int                  rsp_delay = 3;
    int                  gap_after = 0;
    int                  gap_len   = 0;
    bit                  mem_silent = 1'b0;
    logic [BUS_SIZE-1:0] mem_rd_base = '0;
    logic [BUS_SIZE-1:0] exp_rd_base = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .BUS_SIZE(BUS_SIZE), .ADDR_SIZE(ADDR_SIZE),
        .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_cmd_0(req_cmd_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .gnt_0(gnt_0), .wready_0(wready_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .done_0(done_0), .err_0(err_0),
        .req_cmd_1(req_cmd_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .gnt_1(gnt_1), .wready_1(wready_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .done_1(done_1), .err_1(err_1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_command(mem_command)
    );

    // Scoreboard
    typedef struct packed { logic id; logic [BUS_SIZE-1:0] data; } beat_t;
    typedef struct packed { logic id; logic [ADDR_SIZE-1:0] addr; } gnt_t;
    typedef struct packed { logic id; logic err; } done_t;
    beat_t rd_q[$];
    beat_t wr_q[$];
    gnt_t  gnt_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic expect_grant(input logic id, input logic [ADDR_SIZE-1:0] addr);
        gnt_t g;
        g.id = id;
        g.addr = addr;
        gnt_q.push_back(g);
    endtask

    task automatic expect_done(input logic id, input logic err);
        done_t d;
        d.id = id;
        d.err = err;
        done_q.push_back(d);
    endtask

    task automatic expect_read(input logic id, input logic [ADDR_SIZE-1:0] addr);
        beat_t b;
        expect_grant(id, addr);
        for (int k = 0; k < BURST_LEN; k++) begin
            b.id = id;
            b.data = exp_rd_base + BUS_SIZE'(k);
            rd_q.push_back(b);
        end
        exp_rd_base += BUS_SIZE'(16);
        expect_done(id, 1'b0);
    endtask

    task automatic expect_write(input logic id, input logic [ADDR_SIZE-1:0] addr,
                                input logic [BUS_SIZE-1:0] base);
        beat_t b;
        expect_grant(id, addr);
        for (int k = 0; k < BURST_LEN; k++) begin
            b.id = id;
            b.data = base + BUS_SIZE'(k);
            wr_q.push_back(b);
        end
        expect_done(id, 1'b0);
    endtask

    task automatic set_req(input int id, input logic [1:0] cmd,
                           input logic [ADDR_SIZE-1:0] addr, input logic [BUS_SIZE-1:0] wd);
        if (id == 0) begin
            req_cmd_0 = cmd; req_addr_0 = addr; req_wdata_0 = wd;
        end else begin
            req_cmd_1 = cmd; req_addr_1 = addr; req_wdata_1 = wd;
        end
    endtask

    task automatic set_wdata(input int id, input logic [BUS_SIZE-1:0] wd);
        if (id == 0) req_wdata_0 = wd;
        else         req_wdata_1 = wd;
    endtask

    task automatic wait_gnt(input int id, output bit got);
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = (id == 0) ? gnt_0 : gnt_1;
        end
        check_eq("gnt_wait", 32'(got), 32'd1);
    endtask

    // Raise a request, wait for its grant, then drop it (and scramble the
    // address, which must be ignored). Writes present beat k in the k-th
    // cycle of the grant.
    task automatic drive_req(input int id, input logic [1:0] cmd,
                             input logic [ADDR_SIZE-1:0] addr, input logic [BUS_SIZE-1:0] wbase);
        bit got;
        set_req(id, cmd, addr, wbase);
        wait_gnt(id, got);
        set_req(id, C2_NOP, ~addr, wbase);
        if (got && cmd == C2_WRITE) begin
            for (int k = 1; k < BURST_LEN; k++) begin
                @(posedge clk); #1;
                set_wdata(id, wbase + BUS_SIZE'(k));
            end
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((done_q.size() + rd_q.size() + wr_q.size() + gnt_q.size()) != 0 && c < 1000) begin
            @(negedge clk); #1;
            c++;
        end
        check_eq("drain", 32'(done_q.size() + rd_q.size() + wr_q.size() + gnt_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares everything the DUT produces against the queues.
    initial begin : monitor
        logic [1:0] gnt_prev;
        beat_t b;
        gnt_t  g;
        done_t d;
        gnt_prev = 2'b00;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if ({gnt_1, gnt_0}[i] && !gnt_prev[i]) begin
                    check_eq("gnt_unexpected", 32'(gnt_q.size() > 0), 32'd1);
                    check_eq("gnt_onehot", 32'(gnt_0 & gnt_1), 32'd0);
                    if (gnt_q.size() > 0) begin
                        g = gnt_q.pop_front();
                        check_eq("gnt_id", 32'(i), 32'(g.id));
                        check_eq("gnt_addr", 32'(mem_address), 32'(g.addr));
                    end
                end
            end
            gnt_prev = {gnt_1, gnt_0};

            if (rvalid_0 || rvalid_1) begin
                check_eq("rvalid_unexpected", 32'(rd_q.size() > 0), 32'd1);
                if (rd_q.size() > 0) begin
                    b = rd_q.pop_front();
                    check_eq("rvalid_sel", 32'({rvalid_1, rvalid_0}), b.id ? 32'd2 : 32'd1);
                    check_eq("rdata", 32'(rvalid_1 ? rdata_1 : rdata_0), 32'(b.data));
                end
            end

            if (mem_command == C2_WRITE) begin
                check_eq("write_unexpected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) begin
                    b = wr_q.pop_front();
                    check_eq("wready_sel", 32'({wready_1, wready_0}), b.id ? 32'd2 : 32'd1);
                    check_eq("wr_data", 32'(mem_data), 32'(b.data));
                end
            end else if (wready_0 || wready_1) begin
                check_eq("wready_no_write", 32'({wready_1, wready_0}), 32'd0);
            end

            if (done_0 || done_1) begin
                check_eq("done_unexpected", 32'(done_q.size() > 0), 32'd1);
                if (done_q.size() > 0) begin
                    d = done_q.pop_front();
                    check_eq("done_sel", 32'({done_1, done_0}), d.id ? 32'd2 : 32'd1);
                    check_eq("done_err", 32'(d.id ? err_1 : err_0), 32'(d.err));
                    check_eq("done_gnt", 32'({gnt_1, gnt_0}), d.id ? 32'd2 : 32'd1);
                    check_eq("done_bus_released",
                             32'(mem_command == C2_READ || mem_command == C2_WRITE), 32'd0);
                    $display("txn req%0d done err=%0b at %0t", d.id, d.id ? err_1 : err_0, $time);
                end
            end
        end
    end

    // Memory model: answers reads with a (possibly gapped) burst, answers
    // writes with one RESPONSE cycle, or stays silent to provoke a timeout.
    initial begin : memory
        int cnt;
        bit wr_seen;
        mem_cmd_drv  = 1'b0;
        mem_data_drv = 1'b0;
        mem_data_val = '0;
        wr_seen      = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_command == C2_READ) begin
                @(negedge clk);
                check_eq("rd_cmd_one_cycle", 32'(mem_command == C2_READ), 32'd0);
                if (mem_silent) begin
                    cnt = 1;
                    while (!(done_0 || done_1) && cnt < 400) begin
                        @(negedge clk);
                        cnt++;
                    end
                    check_eq("timeout_cycles", 32'(cnt), 32'(TIMEOUT + 1));
                end else begin
                    repeat (rsp_delay - 1) @(negedge clk);
                    for (int k = 0; k < BURST_LEN; k++) begin
                        mem_cmd_drv  = 1'b1;
                        mem_data_drv = 1'b1;
                        mem_data_val = mem_rd_base + BUS_SIZE'(k);
                        @(negedge clk);
                        if (k == gap_after && gap_len > 0) begin
                            mem_cmd_drv  = 1'b0;
                            mem_data_drv = 1'b0;
                            repeat (gap_len) @(negedge clk);
                        end
                    end
                    mem_cmd_drv  = 1'b0;
                    mem_data_drv = 1'b0;
                    mem_rd_base += BUS_SIZE'(16);
                end
            end else if (mem_command == C2_WRITE) begin
                wr_seen = 1'b1;
            end else if (wr_seen) begin
                wr_seen = 1'b0;
                if (gnt_0 || gnt_1) begin
                    @(negedge clk);
                    mem_cmd_drv = 1'b1;
                    @(negedge clk);
                    mem_cmd_drv = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit got;
        reset_n = 1'b0;
        set_req(0, C2_NOP, '0, '0);
        set_req(1, C2_NOP, '0, '0);
        repeat (2) @(posedge clk); #1;

        // Reset state
        check_eq("rst_gnt", 32'({gnt_1, gnt_0}), 32'd0);
        check_eq("rst_wready", 32'({wready_1, wready_0}), 32'd0);
        check_eq("rst_rvalid", 32'({rvalid_1, rvalid_0}), 32'd0);
        check_eq("rst_done_err", 32'({done_1, done_0, err_1, err_0}), 32'd0);
        check_eq("rst_rdata", {rdata_1, rdata_0}, 32'd0);
        check_eq("rst_mem_address", 32'(mem_address), 32'd0);
        check_eq("rst_cmd_released", 32'(mem_command == C2_READ || mem_command == C2_WRITE), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous writes: requester 0 first, then requester 1
        expect_write(0, 15'h0100, 16'hA000);
        expect_write(1, 15'h0200, 16'hB000);
        fork
            drive_req(0, C2_WRITE, 15'h0100, 16'hA000);
            drive_req(1, C2_WRITE, 15'h0200, 16'hB000);
        join
        wait_drain();

        // Single read, memory responds 3 cycles after the command
        rsp_delay = 3;
        expect_read(0, 15'h1A2B);
        drive_req(0, C2_READ, 15'h1A2B, '0);
        wait_drain();

        // Requester 1 holds reads, requester 0 asks once: grants 1,0,1
        expect_read(1, 15'h0333);
        expect_read(0, 15'h0444);
        expect_read(1, 15'h0333);
        req_cmd_1  = C2_READ;
        req_addr_1 = 15'h0333;
        wait_gnt(1, got);
        drive_req(0, C2_READ, 15'h0444, '0);
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = gnt_1;
        end
        check_eq("rr_third_grant", 32'(got), 32'd1);
        req_cmd_1 = C2_NOP;
        wait_drain();

        // RESPONSE drops for 2 cycles after beat 3
        gap_after = 3;
        gap_len   = 2;
        expect_read(1, 15'h0555);
        drive_req(1, C2_READ, 15'h0555, '0);
        wait_drain();
        gap_len = 0;

        // Memory never responds: timeout with err
        mem_silent = 1'b1;
        expect_grant(0, 15'h0666);
        expect_done(0, 1'b1);
        drive_req(0, C2_READ, 15'h0666, '0);
        wait_drain();
        mem_silent = 1'b0;
        check_eq("timeout_back_idle", 32'({gnt_1, gnt_0}), 32'd0);

        // Recovery read after the timeout
        expect_read(1, 15'h0777);
        drive_req(1, C2_READ, 15'h0777, '0);
        wait_drain();

        // Reset asserted in the 4th WR_BURST cycle
        expect_grant(0, 15'h0888);
        for (int k = 0; k < BURST_LEN; k++) begin
            beat_t b;
            b.id = 1'b0;
            b.data = 16'hC000 + 16'(k);
            wr_q.push_back(b);
        end
        set_req(0, C2_WRITE, 15'h0888, 16'hC000);
        wait_gnt(0, got);
        req_cmd_0 = C2_NOP;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            req_wdata_0 = 16'hC000 + 16'(k);
        end
        reset_n = 1'b0;
        #1;
        check_eq("abort_gnt", 32'({gnt_1, gnt_0}), 32'd0);
        check_eq("abort_wready", 32'({wready_1, wready_0}), 32'd0);
        check_eq("abort_cmd_released", 32'(mem_command == C2_WRITE), 32'd0);
        check_eq("abort_mem_address", 32'(mem_address), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("abort_beats_seen", 32'(wr_q.size()), 32'(BURST_LEN - 3));
        wr_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // New request after reset release completes normally
        expect_write(0, 15'h0999, 16'hD000);
        drive_req(0, C2_WRITE, 15'h0999, 16'hD000);
        wait_drain();

        check_eq("queues_empty", 32'(rd_q.size() + wr_q.size() + gnt_q.size() + done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
